// File: rtl/mdu_dispatcher.sv
// Issues RV32M ops to an external MDU; divide-by-zero, signed overflow and cache hits answer
// one cycle after accept without the MDU, everything else responds the cycle after mdu_done.
module mdu_dispatcher (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        mdu_start,
  output logic [2:0]  mdu_operation,
  output logic [31:0] mdu_x,
  output logic [31:0] mdu_y,
  input  logic        mdu_done,
  input  logic [31:0] mdu_result
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t      r_state;
  logic        r_mdu_start;
  logic        r_resp_vld;
  logic [31:0] r_resp_dat;
  logic [4:0]  r_resp_rd;
  logic [2:0]  r_op;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [4:0]  r_rd;

  logic        r_c_vld;
  logic [2:0]  r_c_op;
  logic [31:0] r_c_rs1;
  logic [31:0] r_c_rs2;
  logic [31:0] r_c_result;

  logic        w_accept;
  logic        w_rs2_zero;
  logic        w_ovf;
  logic        w_hit;
  logic        w_fast;
  logic [31:0] w_fast_dat;
  logic        w_done_ok;

  assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;
  assign w_rs2_zero = (req_rs2 == 32'h0000_0000);
  assign w_ovf      = (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
  assign w_hit      = r_c_vld && (r_c_op == req_op) && (r_c_rs1 == req_rs1) && (r_c_rs2 == req_rs2);
  // The start cycle's mdu_done may belong to an abandoned operation.
  assign w_done_ok  = mdu_done && !r_mdu_start;

  always_comb begin
    w_fast     = 1'b0;
    w_fast_dat = 32'h0000_0000;
    case (req_op)
      3'b100: begin
        if (w_rs2_zero) begin
          w_fast     = 1'b1;
          w_fast_dat = 32'hFFFF_FFFF;
        end else if (w_ovf) begin
          w_fast     = 1'b1;
          w_fast_dat = 32'h8000_0000;
        end
      end
      3'b101: begin
        if (w_rs2_zero) begin
          w_fast     = 1'b1;
          w_fast_dat = 32'hFFFF_FFFF;
        end
      end
      3'b110: begin
        if (w_rs2_zero) begin
          w_fast     = 1'b1;
          w_fast_dat = req_rs1;
        end else if (w_ovf) begin
          w_fast     = 1'b1;
          w_fast_dat = 32'h0000_0000;
        end
      end
      3'b111: begin
        if (w_rs2_zero) begin
          w_fast     = 1'b1;
          w_fast_dat = req_rs1;
        end
      end
      default: ;
    endcase
    if (!w_fast && w_hit) begin
      w_fast     = 1'b1;
      w_fast_dat = r_c_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mdu_start <= 1'b0;
      r_resp_vld  <= 1'b0;
      r_resp_dat  <= 32'h0000_0000;
      r_resp_rd   <= 5'd0;
      r_op        <= 3'd0;
      r_rs1       <= 32'h0000_0000;
      r_rs2       <= 32'h0000_0000;
      r_rd        <= 5'd0;
      r_c_vld     <= 1'b0;
      r_c_op      <= 3'd0;
      r_c_rs1     <= 32'h0000_0000;
      r_c_rs2     <= 32'h0000_0000;
      r_c_result  <= 32'h0000_0000;
    end else begin
      r_mdu_start <= 1'b0;
      r_resp_vld  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= req_op;
            r_rs1 <= req_rs1;
            r_rs2 <= req_rs2;
            r_rd  <= req_rd;
            if (w_fast) begin
              r_resp_vld <= 1'b1;
              r_resp_dat <= w_fast_dat;
              r_resp_rd  <= req_rd;
            end else begin
              r_mdu_start <= 1'b1;
              r_state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= w_done_ok ? S_IDLE : S_DRAIN;
          end else if (w_done_ok) begin
            r_resp_vld <= 1'b1;
            r_resp_dat <= mdu_result;
            r_resp_rd  <= r_rd;
            r_c_vld    <= 1'b1;
            r_c_op     <= r_op;
            r_c_rs1    <= r_rs1;
            r_c_rs2    <= r_rs2;
            r_c_result <= mdu_result;
            r_state    <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mdu_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign stall         = (r_state != S_IDLE);
  assign resp_valid    = r_resp_vld;
  assign resp_data     = r_resp_dat;
  assign resp_rd       = r_resp_rd;
  assign mdu_start     = r_mdu_start;
  assign mdu_operation = r_op;
  assign mdu_x         = r_rs1;
  assign mdu_y         = r_rs2;

endmodule

// File: tb/tb_mdu_dispatcher.sv
// Bench for mdu_dispatcher: behavioural MDU with programmable latency, response scoreboard,
// a vector table for the main paths and hand sequences for flush/drain/reset corners.
module tb_mdu_dispatcher;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        mdu_start;
  logic [2:0]  mdu_operation;
  logic [31:0] mdu_x;
  logic [31:0] mdu_y;
  logic        mdu_done;
  logic [31:0] mdu_result;

  mdu_dispatcher dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .flush(flush), .stall(stall),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .mdu_start(mdu_start), .mdu_operation(mdu_operation), .mdu_x(mdu_x), .mdu_y(mdu_y),
    .mdu_done(mdu_done), .mdu_result(mdu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_resp  = 0;

  typedef struct {
    logic [36:0] exp;
  } exp_t;
  logic [36:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural MDU: answers m_lat cycles after the start pulse.
  int          m_lat = 4;
  int          m_cnt = 0;
  logic [2:0]  m_op;
  logic [31:0] m_x;
  logic [31:0] m_y;

  function automatic logic [31:0] mdu_calc(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int sx;
    int sy;
    sx = x;
    sy = y;
    p  = 64'd0;
    case (op)
      3'b000: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      3'b001: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
      3'b010: begin p = {{32{x[31]}}, x} * {32'd0, y}; return p[63:32]; end
      3'b011: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      3'b100: return (y == 0) ? 32'hFFFF_FFFF : (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? x : 32'(sx / sy);
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: return (y == 0) ? x : (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'd0 : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  always @(negedge clk) begin
    mdu_done = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mdu_done   = 1'b1;
        mdu_result = mdu_calc(m_op, m_x, m_y);
      end
    end
    if (mdu_start) begin
      m_op  = mdu_operation;
      m_x   = mdu_x;
      m_y   = mdu_y;
      m_cnt = m_lat;
    end
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (mdu_start) n_start++;
    if (resp_valid) begin
      n_resp++;
      if (sb_q.size() == 0) begin
        chk("resp_unexpected", {27'd0, resp_rd}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("resp_data", resp_data, e[31:0]);
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, e[36:32]});
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        slow;
  } rec_t;

  task automatic send(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] rd);
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (!req_ready) chk("send_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_rd    = rd;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input rec_t r);
    int  s0;
    bit  got;
    bit  stall_ok;
    s0       = n_start;
    got      = 1'b0;
    stall_ok = 1'b1;
    sb_q.push_back({r.rd, r.exp});
    send(r.op, r.rs1, r.rs2, r.rd);
    if (r.slow) chk("start_ops", {mdu_start, mdu_operation, mdu_x[13:0], mdu_y[13:0]},
                    {1'b1, r.op, r.rs1[13:0], r.rs2[13:0]});
    else        chk("fast_latency", {31'd0, resp_valid}, 32'd1);
    for (int k = 0; k < 200; k++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      if (!stall) stall_ok = 1'b0;
      @(negedge clk); #1;
    end
    chk("resp_seen", {31'd0, got}, 32'd1);
    if (r.slow) chk("stall_during_op", {31'd0, stall_ok}, 32'd1);
    chk("ready_at_resp", {31'd0, req_ready}, 32'd1);
    chk("start_count", 32'(n_start - s0), {31'd0, r.slow});
  endtask

  rec_t tbl[18];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    bit seen;
    bit stall_ok;

    tbl[0]  = '{3'b000, 32'd7,         32'd6,         5'd1,  32'd42,        1'b1};
    tbl[1]  = '{3'b100, 32'd100,       32'd0,         5'd2,  32'hFFFF_FFFF, 1'b0};
    tbl[2]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'd0,         1'b0};
    tbl[3]  = '{3'b101, 32'd50,        32'd5,         5'd4,  32'd10,        1'b1};
    tbl[4]  = '{3'b101, 32'd50,        32'd5,         5'd5,  32'd10,        1'b0};
    tbl[5]  = '{3'b101, 32'd50,        32'd6,         5'd6,  32'd8,         1'b1};
    tbl[6]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1'b0};
    tbl[7]  = '{3'b111, 32'd123,       32'd0,         5'd8,  32'd123,       1'b0};
    tbl[8]  = '{3'b101, 32'd7,         32'd0,         5'd9,  32'hFFFF_FFFF, 1'b0};
    tbl[9]  = '{3'b101, 32'd50,        32'd6,         5'd10, 32'd8,         1'b0};
    tbl[10] = '{3'b001, 32'hFFFF_FFFF, 32'd2,         5'd0,  32'hFFFF_FFFF, 1'b1};
    tbl[11] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 1'b1};
    tbl[12] = '{3'b110, 32'hFFFF_FFF9, 32'd3,         5'd12, 32'hFFFF_FFFF, 1'b1};
    tbl[13] = '{3'b110, 32'hFFFF_FFF9, 32'd3,         5'd13, 32'hFFFF_FFFF, 1'b0};
    tbl[14] = '{3'b111, 32'hFFFF_FFF9, 32'd3,         5'd14, 32'd0,         1'b1};
    tbl[15] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFF, 1'b1};
    tbl[16] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'd1,         1'b1};
    tbl[17] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1'b1};

    reset = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    req_rd = 5'd0; flush = 1'b0; mdu_done = 1'b0; mdu_result = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", {28'd0, mdu_start, resp_valid, stall, req_ready}, 32'h1);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_mdu_xy", mdu_x | mdu_y | {24'd0, resp_rd, mdu_operation}, 32'd0);
    reset = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      m_lat = (i == 0) ? 10 : 3 + (i % 4);
      issue(tbl[i]);
    end
    @(negedge clk); #1;
    chk("hold_after_pulse", {resp_valid, resp_rd, resp_data[25:0]}, {1'b0, 5'd17, 26'h0});
    chk("hold_data", resp_data, 32'h8000_0000);

    // Flush three cycles into the operation: drain until the MDU finishes.
    m_lat = 20;
    s0 = n_resp;
    send(3'b000, 32'd11, 32'd13, 5'd18);
    repeat (3) begin @(negedge clk); #1; end
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    chk("drain_entered", {30'd0, stall, req_ready}, 32'h2);
    seen = 1'b0; stall_ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (mdu_done) begin seen = 1'b1; break; end
      if (!stall) stall_ok = 1'b0;
      @(negedge clk); #1;
    end
    chk("drain_stall_held", {30'd0, seen, stall_ok}, 32'h3);
    @(negedge clk); #1;
    chk("drain_exit", {29'd0, resp_valid, stall, req_ready}, 32'h1);
    chk("drain_no_resp", 32'(n_resp - s0), 32'd0);
    m_lat = 4;
    issue('{3'b000, 32'd11, 32'd13, 5'd19, 32'd143, 1'b1});

    // Flush coincident with mdu_done: result dropped, back to IDLE.
    m_lat = 5;
    s0 = n_resp;
    send(3'b000, 32'd3, 32'd5, 5'd20);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (mdu_done) begin flush = 1'b1; seen = 1'b1; break; end
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    flush = 1'b0;
    chk("flushdone_idle", {28'd0, seen, resp_valid, stall, req_ready}, 32'h9);
    repeat (2) begin @(negedge clk); #1; end
    chk("flushdone_no_resp", 32'(n_resp - s0), 32'd0);
    m_lat = 3;
    issue('{3'b000, 32'd3, 32'd5, 5'd21, 32'd15, 1'b1});

    // Reset in the middle of WAIT, then a stray mdu_done after release.
    m_lat = 10;
    send(3'b000, 32'd9, 32'd9, 5'd22);
    repeat (3) begin @(negedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("midrst_ctrl", {28'd0, mdu_start, resp_valid, stall, req_ready}, 32'h1);
    chk("midrst_resp_data", resp_data, 32'd0);
    chk("midrst_mdu_x", mdu_x, 32'd0);
    chk("midrst_mdu_y_rd_op", mdu_y | {24'd0, resp_rd, mdu_operation}, 32'd0);
    repeat (2) begin @(negedge clk); #1; end
    reset = 1'b1;
    s0 = n_start;
    r0 = n_resp;
    repeat (15) begin @(negedge clk); #1; end
    chk("stray_no_resp", 32'(n_resp - r0), 32'd0);
    chk("stray_no_start", 32'(n_start - s0), 32'd0);
    chk("stray_idle", {30'd0, stall, req_ready}, 32'h1);
    m_lat = 3;
    issue('{3'b000, 32'd3, 32'd5, 5'd23, 32'd15, 1'b1});

    repeat (3) begin @(negedge clk); #1; end
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
